// File: rtl/cache_pkg.sv
// cache_pkg: shared line geometry, fill FSM state encoding and address helpers
package cache_pkg;
    localparam int WORDS_PER_LINE = 8;
    localparam int WORD_BITS = 32;
    localparam int LINE_BITS = WORDS_PER_LINE * WORD_BITS;
    localparam int WORD_OFS_BITS = 3;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} fill_state_t;
    typedef logic [WORD_OFS_BITS-1:0] word_ofs_t;

    function automatic word_ofs_t word_ofs(input logic [31:0] addr);
        return addr[WORD_OFS_BITS+1:2];
    endfunction
endpackage

// File: rtl/linefill_buf.sv
// linefill_buf: 8x32 line assembly buffer with wrapping write pointer and beat counter
module linefill_buf
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  word_ofs_t            start_word,
    input  logic                 we,
    input  logic [WORD_BITS-1:0] wdata,
    output word_ofs_t            wptr,
    output logic                 last,
    output logic [LINE_BITS-1:0] line
);
    logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0] mem;
    word_ofs_t cnt;

    // store beats at the pointer; the 3-bit pointer wraps 7 -> 0 on its own
    always_ff @(posedge clk) begin
        if (rst) begin
            mem  <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (start) begin
            wptr <= start_word;
            cnt  <= '0;
        end else if (we) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
            cnt       <= cnt + 1'b1;
        end
    end

    assign last = we && (cnt == word_ofs_t'(WORDS_PER_LINE - 1));
    assign line = mem;
endmodule

// File: rtl/cache_linefill.sv
// cache_linefill: miss-driven 8-beat burst fill into the line RAM; CRITICAL_WORD_FIRST_EN starts the burst at the missed word
module cache_linefill
    import cache_pkg::*;
#(
    parameter int NL  = 128,
    parameter int LSS = 7
) (
    input  logic                 nGCLK,
    input  logic                 rst,
    input  logic                 miss_req,
    input  logic [31:0]          miss_addr,
    output logic                 bus_req,
    output logic [31:0]          bus_addr,
    input  logic                 bus_ack,
    input  logic [31:0]          bus_rdata,
    input  logic                 bus_err,
    output logic [LSS-1:0]       write_sel,
    output logic [LINE_BITS-1:0] write_port,
    output logic                 wr_ena,
    output logic                 crit_valid,
    output logic [31:0]          crit_data,
    output logic                 busy,
    output logic                 fill_done,
    output logic                 fill_err
);
    fill_state_t state, state_n;
    word_ofs_t   start_word, req_ofs, wptr;
    logic        start, beat_we, beat_last, crit_hit;
    logic        unused_ok;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_word = word_ofs(miss_addr);
`else
    assign start_word = '0;
`endif

    assign unused_ok = ^{miss_addr[1:0], 32'(NL)};

    linefill_buf u_buf (
        .clk        (nGCLK),
        .rst        (rst),
        .start      (start),
        .start_word (start_word),
        .we         (beat_we),
        .wdata      (bus_rdata),
        .wptr       (wptr),
        .last       (beat_last),
        .line       (write_port)
    );

    // state register
    always_ff @(posedge nGCLK) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state: an error beat wins over an ack and drops straight back to IDLE
    always_comb begin
        state_n = (state == IDLE)  ? (miss_req ? FILL : IDLE) :
                  (state == FILL)  ? (bus_err ? IDLE : (beat_last ? WRITE : FILL)) :
                  (state == WRITE) ? DONE : IDLE;
    end

    // state decodes: bus handshake, buffer control and critical-word match
    always_comb begin
        bus_req  = (state == FILL);
        busy     = (state != IDLE);
        start    = (state == IDLE) && miss_req;
        beat_we  = (state == FILL) && bus_ack && !bus_err;
        crit_hit = beat_we && (wptr == req_ofs);
    end

    // registered outputs and latched request fields
    always_ff @(posedge nGCLK) begin
        if (rst) begin
            bus_addr   <= '0;
            write_sel  <= '0;
            req_ofs    <= '0;
            wr_ena     <= 1'b0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            fill_done  <= 1'b0;
            fill_err   <= 1'b0;
        end else begin
            wr_ena     <= beat_last;
            crit_valid <= crit_hit;
            fill_done  <= (state == WRITE);
            fill_err   <= (state == FILL) && bus_err;
            if (crit_hit) crit_data <= bus_rdata;
            if (start) begin
                bus_addr  <= {miss_addr[31:5], start_word, 2'b00};
                write_sel <= miss_addr[LSS+4:5];
                req_ofs   <= word_ofs(miss_addr);
            end
        end
    end
endmodule

// File: tb/tb_cache_linefill.sv
// tb_cache_linefill: directed fills with a scoreboard of expected bus, critical-word, write and status events
module tb_cache_linefill;
    localparam int LSS = 7;

    typedef struct {
        int             cyc;
        logic [LSS-1:0] sel;
        logic [255:0]   val;
    } ev_t;

    logic           nGCLK = 1'b0;
    logic           rst = 1'b1;
    logic           miss_req = 1'b0;
    logic [31:0]    miss_addr = '0;
    logic           bus_ack = 1'b0;
    logic [31:0]    bus_rdata = '0;
    logic           bus_err = 1'b0;
    logic           bus_req, wr_ena, crit_valid, busy, fill_done, fill_err;
    logic [31:0]    bus_addr, crit_data;
    logic [LSS-1:0] write_sel;
    logic [255:0]   write_port;

    ev_t addr_q[$], crit_q[$], wr_q[$], done_q[$], err_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    logic prev_req = 1'b0;

    cache_linefill #(.NL(128), .LSS(LSS)) dut (
        .nGCLK      (nGCLK),
        .rst        (rst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err),
        .write_sel  (write_sel),
        .write_port (write_port),
        .wr_ena     (wr_ena),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .busy       (busy),
        .fill_done  (fill_done),
        .fill_err   (fill_err)
    );

    always #5 nGCLK = ~nGCLK;

    always @(posedge nGCLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_bus_req"}, 256'(bus_req), 256'(0));
        check({nm, "_busy"}, 256'(busy), 256'(0));
        check({nm, "_wr_ena"}, 256'(wr_ena), 256'(0));
        check({nm, "_crit_valid"}, 256'(crit_valid), 256'(0));
        check({nm, "_fill_done"}, 256'(fill_done), 256'(0));
        check({nm, "_fill_err"}, 256'(fill_err), 256'(0));
        check({nm, "_bus_addr"}, 256'(bus_addr), 256'(0));
        check({nm, "_write_sel"}, 256'(write_sel), 256'(0));
        check({nm, "_write_port"}, write_port, 256'(0));
        check({nm, "_crit_data"}, 256'(crit_data), 256'(0));
    endtask

    // monitor: pop the expected event whenever the DUT presents one
    always @(negedge nGCLK) begin
        ev_t e;
        if (bus_req && !prev_req) begin
            if (addr_q.size() == 0) check("bus_addr_unexpected", 256'(1), 256'(0));
            else begin
                e = addr_q.pop_front();
                check("bus_addr", 256'(bus_addr), e.val);
            end
        end
        prev_req = bus_req;
        if (crit_valid) begin
            if (crit_q.size() == 0) check("crit_unexpected", 256'(1), 256'(0));
            else begin
                e = crit_q.pop_front();
                check("crit_cycle", 256'(cyc), 256'(e.cyc));
                check("crit_data", 256'(crit_data), e.val);
            end
        end
        if (wr_ena) begin
            if (wr_q.size() == 0) check("wr_ena_unexpected", 256'(1), 256'(0));
            else begin
                e = wr_q.pop_front();
                check("wr_cycle", 256'(cyc), 256'(e.cyc));
                check("write_sel", 256'(write_sel), 256'(e.sel));
                check("write_port", write_port, e.val);
            end
        end
        if (fill_done) begin
            if (done_q.size() == 0) check("done_unexpected", 256'(1), 256'(0));
            else begin
                e = done_q.pop_front();
                check("done_cycle", 256'(cyc), 256'(e.cyc));
            end
        end
        if (fill_err) begin
            if (err_q.size() == 0) check("err_unexpected", 256'(1), 256'(0));
            else begin
                e = err_q.pop_front();
                check("err_cycle", 256'(cyc), 256'(e.cyc));
            end
        end
    end

    // one fill starting in the current cycle; word w carries base+w; beat 8 means "never"
    task automatic run_fill(input logic [31:0] addr, input logic [31:0] exp_ba, input logic [LSS-1:0] exp_sel,
                            input logic [7:0] base, input int gap, input int err_beat, input int rst_beat,
                            input bit poke);
        ev_t e;
        int c0, k, w, sw, ofs;
        ofs = int'(addr[4:2]);
`ifdef CRITICAL_WORD_FIRST_EN
        sw = ofs;
`else
        sw = 0;
`endif
        c0 = cyc;
        miss_req = 1'b1;
        miss_addr = addr;
        e.cyc = 0;
        e.sel = exp_sel;
        e.val = 256'(exp_ba);
        addr_q.push_back(e);
        k = (ofs - sw + 8) % 8;
        if (k < err_beat && k < rst_beat) begin
            e.cyc = c0 + 2 + k * (gap + 1);
            e.val = 256'(32'(base) + 32'(ofs));
            crit_q.push_back(e);
        end
        if (err_beat < 8) begin
            e.cyc = c0 + 2 + err_beat * (gap + 1);
            err_q.push_back(e);
        end else if (rst_beat == 8) begin
            e.cyc = c0 + 2 + 7 * (gap + 1);
            e.val = '0;
            for (int i = 0; i < 8; i++) e.val[32*i +: 32] = 32'(base) + 32'(i);
            wr_q.push_back(e);
            e.cyc = e.cyc + 1;
            done_q.push_back(e);
        end
        @(posedge nGCLK); #1;
        miss_req = 1'b0;
        w = sw;
        for (int b = 0; b < 8; b++) begin
            if (b == rst_beat) begin
                rst = 1'b1;
                bus_ack = 1'b1;
                bus_rdata = 32'hBAD0_0000;
                @(posedge nGCLK); #1;
                rst = 1'b0;
                bus_ack = 1'b0;
                check_reset_outputs("rst_abort");
                return;
            end
            bus_ack = 1'b1;
            bus_err = (b == err_beat);
            bus_rdata = (b == err_beat) ? 32'hE77E_E77E : 32'(base) + 32'(w);
            if (poke) begin
                miss_req = 1'b1;
                miss_addr = 32'hFFFF_FFE0;
            end
            @(posedge nGCLK); #1;
            bus_ack = 1'b0;
            miss_req = 1'b0;
            if (b == err_beat) begin
                bus_err = 1'b0;
                check("err_busy", 256'(busy), 256'(0));
                check("err_bus_req", 256'(bus_req), 256'(0));
                return;
            end
            w = (w + 1) % 8;
            if (b < 7) repeat (gap) begin
                miss_req = poke;
                @(posedge nGCLK); #1;
                miss_req = 1'b0;
            end
        end
        repeat (2) begin
            @(posedge nGCLK); #1;
        end
    endtask

    initial begin
        repeat (3) begin
            @(posedge nGCLK); #1;
        end
        check_reset_outputs("reset");
        rst = 1'b0;
        run_fill(32'h0000_1A40, 32'h0000_1A40, 7'h52, 8'hA0, 0, 8, 8, 1'b0);
`ifdef CRITICAL_WORD_FIRST_EN
        run_fill(32'h0000_0034, 32'h0000_0034, 7'h01, 8'h50, 0, 8, 8, 1'b0);
        run_fill(32'h0000_2468, 32'h0000_2468, 7'h23, 8'hC0, 1, 8, 8, 1'b1);
`else
        run_fill(32'h0000_0034, 32'h0000_0020, 7'h01, 8'h50, 0, 8, 8, 1'b0);
        run_fill(32'h0000_2468, 32'h0000_2460, 7'h23, 8'hC0, 1, 8, 8, 1'b1);
`endif
        run_fill(32'h0000_0100, 32'h0000_0100, 7'h08, 8'h10, 0, 3, 8, 1'b0);
        run_fill(32'h0000_0FE0, 32'h0000_0FE0, 7'h7F, 8'h70, 0, 8, 8, 1'b0);
        run_fill(32'h0000_0040, 32'h0000_0040, 7'h02, 8'h30, 0, 8, 3, 1'b0);
`ifdef CRITICAL_WORD_FIRST_EN
        run_fill(32'h0000_009C, 32'h0000_009C, 7'h04, 8'h90, 0, 8, 8, 1'b0);
`else
        run_fill(32'h0000_009C, 32'h0000_0080, 7'h04, 8'h90, 0, 8, 8, 1'b0);
`endif
        repeat (4) begin
            @(posedge nGCLK); #1;
        end
        check("addr_q_drained", 256'(addr_q.size()), 256'(0));
        check("crit_q_drained", 256'(crit_q.size()), 256'(0));
        check("wr_q_drained", 256'(wr_q.size()), 256'(0));
        check("done_q_drained", 256'(done_q.size()), 256'(0));
        check("err_q_drained", 256'(err_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cache_linefill.md
Name: cache_linefill

Overview:
- Write-side engine for the 256-bit cache line RAM. It accepts a miss request and issues an 8-beat, 32-bit burst read on the memory bus.
- It assembles the returned words into one line, then performs a single-cycle line write (write_sel, write_port, wr_ena) into the cache RAM.
- It forwards the requested word to the core for early restart. It sits between the cache controller miss logic and the external memory interface.

Parameters:
- NL, 128, number of cache lines.
- LSS, 7, line select bits = log2(NL).

Ports:
- nGCLK  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_req  in  1  start a fill; sampled only in IDLE.
- miss_addr  in  32  byte address of the missing word.
- bus_req  out  1  burst read request, held for the whole burst.
- bus_addr  out  32  burst start address, word aligned.
- bus_ack  in  1  one data beat valid this cycle.
- bus_rdata  in  32  beat data.
- bus_err  in  1  beat error; aborts the fill.
- write_sel  out  LSS  RAM line index.
- write_port  out  256  assembled line; word w occupies bits [32w+31:32w].
- wr_ena  out  1  RAM write strobe, one cycle.
- crit_valid  out  1  one-cycle pulse: requested word available.
- crit_data  out  32  requested word, qualified by crit_valid.
- busy  out  1  fill in progress (not IDLE).
- fill_done  out  1  one-cycle pulse: line written.
- fill_err  out  1  one-cycle pulse: fill aborted.

Behaviour:
- Reset: state=IDLE. bus_req, wr_ena, crit_valid, busy, fill_done and fill_err are 0. bus_addr, write_sel, write_port and crit_data are 0. Line buffer and counters are cleared.
- Asserting rst in any state aborts immediately: there is no RAM write, and bus_req is low on the next cycle.
- Address split:
  - line index = miss_addr[LSS+4:5]
  - word offset = miss_addr[4:2]
  - bits [1:0] are ignored.
- State IDLE: if miss_req=1, latch address, line index and start word, then go to FILL.
- State FILL: bus_req=1; bus_addr = {latched addr[31:5], start_word, 2'b00}.
  - Each cycle with bus_ack=1: store bus_rdata into buffer word wptr; wptr = wptr+1 mod 8 (3-bit wrap); beat counter increments.
  - When the stored word index equals the requested word offset, assert crit_valid with crit_data=bus_rdata in the next cycle (registered).
  - On the 8th ack, go to WRITE; bus_req drops in the next cycle.
  - bus_ack=0 is a wait state; there is no timeout.
- State WRITE: wr_ena=1 for exactly one cycle; write_sel = latched line index; write_port = full buffer. Next state is DONE.
- State DONE: fill_done=1 for one cycle, then go to IDLE. busy is deasserted in IDLE.
- Abort: bus_err=1 in FILL takes priority over a simultaneous bus_ack. That beat's data is discarded, fill_err pulses next cycle, the FSM returns to IDLE, and wr_ena is never asserted.
- miss_req outside IDLE is ignored and not queued. The controller must hold or re-issue it.
- Minimum latency with ack every cycle:
  - miss_req at cycle 0
  - acks at cycles 1..8
  - wr_ena at cycle 9
  - fill_done at cycle 10
  - next miss accepted at cycle 11
- Outputs are registered, except bus_req and busy, which decode from the state register.

Optional Feature:
- CRITICAL_WORD_FIRST_EN defined: start_word = miss word offset. The burst wraps (e.g. offset 5 gives order 5,6,7,0,1,2,3,4), so crit_valid follows the first beat.
- Not defined: start_word = 0 and beats arrive in order 0..7. crit_valid still pulses when the requested word arrives, and the bus_addr low bits [4:0] are 0.

Decomposition:
- Shared package (cache_pkg):
  - WORDS_PER_LINE=8
  - LINE_BITS=256
  - WORD_OFS_BITS=3
  - fill state enumeration (IDLE, FILL, WRITE, DONE)
- One natural sub-module: linefill_buf, the 8x32 line assembly buffer with write pointer, wrap logic and beat counter. The FSM and port logic stay in the top.

Test Plan:
- Offset-0 fill: miss_addr=0x0000_1A40, acks every cycle with data 0xA0..0xA7 -> bus_addr=0x0000_1A40, write_sel=0x52, write_port word w = 0xA0+w, wr_ena at cycle 9, fill_done at cycle 10.
- Critical word (feature on): miss_addr=0x0000_0034 (offset 5), data 0x55 on first ack -> bus_addr=0x0000_0034, crit_valid with 0x55 at cycle 2, RAM word 5=0x55, words wrap 6,7,0..4.
- Same address, feature off -> bus_addr=0x0000_0020, crit_valid at cycle 7 (6th beat).
- Wait states: ack deasserted every other cycle -> exactly 8 beats stored, wr_ena after the 8th ack, and miss_req pulses during FILL are ignored.
- bus_err on the 4th beat -> fill_err pulse, no wr_ena, busy=0 next cycle, and a new miss_req is accepted.
- rst asserted during FILL beat 3 -> all outputs at reset values next cycle, no wr_ena, and the following miss completes normally.
